// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution for the 8-bit core: next-PC selection, Start/Done handshake,
// retired-instruction counter. Define PC_BRANCH_LUT_EN to use a 16-entry absolute target LUT.
module pc_branch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             Halt,
  input  logic             Zero,
  input  logic [3:0]       Offset,
  input  logic             LutWe,
  input  logic [3:0]       LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             take_target;

`ifdef PC_BRANCH_LUT_EN
  logic [PC_W-1:0] lut [16];

  // NOTE: the LUT must clear on reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  // Read is combinational from the current array, so a same-cycle write is seen only next cycle.
  assign target = lut[Offset];
`else
  logic unused_lut_port;
  assign unused_lut_port = ^{LutWe, LutAddr, LutData};

  assign target = ProgCtr + {{(PC_W-4){Offset[3]}}, Offset};
`endif

  assign take_target = Jump | (Branch & Zero);
  assign pc_inc      = ProgCtr + PC_W'(1);
  assign cnt_next    = (InstCount == {CNT_W{1'b1}}) ? InstCount : InstCount + CNT_W'(1);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      ProgCtr   <= '0;
      Running   <= 1'b0;
      Done      <= 1'b0;
      InstCount <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state     <= RUN;
            ProgCtr   <= '0;
            InstCount <= '0;
            Running   <= 1'b1;
            Done      <= 1'b0;
          end
        end
        RUN: begin
          InstCount <= cnt_next;
          if (Halt) begin
            state   <= HALTED;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (take_target) begin
            ProgCtr <= target;
          end else begin
            ProgCtr <= pc_inc;
          end
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized scoreboard bench for pc_branch_unit: driver pushes model predictions, monitor compares.
module tb_pc_branch_unit;
  localparam int PC_W    = 10;
  localparam int CNT_W   = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b1;
  logic             Start = 1'b0, Branch = 1'b0, Jump = 1'b0, Halt = 1'b0, Zero = 1'b0;
  logic [3:0]       Offset = '0;
  logic             LutWe = 1'b0;
  logic [3:0]       LutAddr = '0;
  logic [PC_W-1:0]  LutData = '0;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running, Done;
  logic [CNT_W-1:0] InstCount;

  pc_branch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Branch(Branch), .Jump(Jump),
    .Halt(Halt), .Zero(Zero), .Offset(Offset), .LutWe(LutWe), .LutAddr(LutAddr),
    .LutData(LutData), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t  sb[$];
  event  async_ev;
  int    n_checks = 0;
  int    n_pass = 0;
  string cur_tag = "init";

  // Reference model: program state as plain integers.
  bit m_running = 0, m_done = 0;
  int m_pc = 0, m_cnt = 0;
  int m_lut[16];

  task automatic check(input exp_t e);
    n_checks++;
    if (ProgCtr === e.pc && Running === e.running && Done === e.done && InstCount === e.cnt)
      n_pass++;
    else
      $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, expected pc=%h run=%b done=%b cnt=%0d",
               e.tag, ProgCtr, Running, Done, InstCount, e.pc, e.running, e.done, e.cnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk or async_ev);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e);
      end
    end
  end

  function automatic void push_exp();
    exp_t e;
    e.pc      = PC_W'(m_pc);
    e.running = m_running;
    e.done    = m_done;
    e.cnt     = CNT_W'(m_cnt);
    e.tag     = cur_tag;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    m_running = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endfunction

  function automatic void model_step(input bit s, b, j, h, z, input bit [3:0] off,
                                     input bit lwe, input bit [3:0] la, input int ld);
    int tgt;
`ifdef PC_BRANCH_LUT_EN
    tgt = m_lut[off];
`else
    tgt = m_pc + ((off >= 8) ? int'(off) - 16 : int'(off));
`endif
    if (!m_running) begin
      if (s) begin
        m_running = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (h) begin
        m_running = 0; m_done = 1;
      end else if (j || (b && z)) begin
        m_pc = ((tgt % PC_MOD) + PC_MOD) % PC_MOD;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
`ifdef PC_BRANCH_LUT_EN
    if (lwe) m_lut[la] = ld;
`endif
  endfunction

  task automatic step(input bit s, b, j, h, z, input bit [3:0] off,
                      input bit lwe = 0, input bit [3:0] la = 0, input int ld = 0);
    @(negedge Clk);
    Start = s; Branch = b; Jump = j; Halt = h; Zero = z; Offset = off;
    LutWe = lwe; LutAddr = la; LutData = PC_W'(ld);
    model_step(s, b, j, h, z, off, lwe, la, ld);
    push_exp();
  endtask

  task automatic nop(input int n = 1);
    repeat (n) step(0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic start_prog();
    step(1, 0, 0, 0, 0, 4'd0);
  endtask

  // Reset asserted between edges; outputs are checked before the next clock edge.
  task automatic mid_reset(input string tag);
    @(negedge Clk);
    #1;
    cur_tag = tag;
    Reset_n = 1'b0;
    Start = 0; Branch = 0; Jump = 0; Halt = 0; Zero = 0; Offset = '0; LutWe = 0;
    model_reset();
    push_exp();
    ->async_ev;
    #2;
    Reset_n = 1'b1;
    model_step(0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    push_exp();
  endtask

  initial begin : driver
    bit [3:0] off_br, off_wrap;
    bit s, b, j, h, z, lwe;
`ifdef PC_BRANCH_LUT_EN
    off_br = 4'd2; off_wrap = 4'd1;
`else
    off_br = 4'd13; off_wrap = 4'd15;
`endif
    model_reset();
    mid_reset("reset");

    cur_tag = "seq_run";
    start_prog();
    nop(5);

    cur_tag = "halt";
    start_prog();
    nop(3);
    step(0, 0, 0, 1, 0, 4'd0);
    cur_tag = "halted_hold";
    nop(10);
    cur_tag = "restart";
    start_prog();

    cur_tag = "branch_taken";
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'd2, 'h150);
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'd1, 'h3FF);
    start_prog();
    nop(7);
    step(0, 1, 0, 0, 1, off_br);
    cur_tag = "branch_not_taken";
    start_prog();
    nop(7);
    step(0, 1, 0, 0, 0, off_br);

    cur_tag = "halt_jump_branch";
    step(0, 1, 1, 1, 1, off_br);
    nop(2);

    cur_tag = "wrap";
    start_prog();
    step(0, 0, 1, 0, 0, off_wrap);
    nop(2);

    cur_tag = "run_to_0x40";
    start_prog();
    nop(64);
    mid_reset("reset_mid_run");
    cur_tag = "lut_cleared";
    start_prog();
    step(0, 0, 1, 0, 0, 4'd2);

    cur_tag = "lut_collision";
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'd5, 'h010);
    step(0, 0, 1, 0, 0, 4'd5, 1, 4'd5, 'h020);
    nop(1);
    step(0, 0, 1, 0, 0, 4'd5);

    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(199) == 0) begin
        mid_reset("random_reset");
        cur_tag = "random";
      end
      s   = ($urandom_range(11) == 0);
      h   = ($urandom_range(24) == 0);
      j   = ($urandom_range(5) == 0);
      b   = ($urandom_range(2) == 0);
      z   = ($urandom_range(1) == 0);
      lwe = ($urandom_range(3) == 0);
      step(s, b, j, h, z, 4'($urandom), lwe, 4'($urandom), int'($urandom_range(PC_MOD - 1)));
    end

    cur_tag = "drain";
    nop(1);
    repeat (3) @(negedge Clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
